// File: rtl/fanout_bcast_ctrl.sv
// One-to-many broadcast controller: holds a single upstream token and offers it
// to every enabled destination until each has taken it, then counts the transfer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no token held; accepts a token when the mask is nonzero
// HOLD  | one token held; pending bits mark destinations still to take it
module fanout_bcast_ctrl #(
    parameter int NUM_DEST = 7,
    parameter int DATA_W   = 17,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_DEST-1:0] cfg_mask,
    input  logic                cfg_load,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [NUM_DEST-1:0] out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic [NUM_DEST-1:0] out_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    xfer_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_DEST-1:0] mask_q;
    logic [NUM_DEST-1:0] mask_nxt;
    logic [NUM_DEST-1:0] pending_q;
    logic [NUM_DEST-1:0] pending_nxt;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_nxt;
    logic [CNT_W-1:0]    count_q;
    logic                mask_nz;
    logic                last_clear;
    logic                accept;
    logic                count_inc;

    assign mask_nz    = |mask_q;
    // True when every destination still pending completes its handshake now.
    assign last_clear = ((pending_q & ~out_ready) == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            mask_q    <= '0;
            pending_q <= '0;
            data_q    <= '0;
            count_q   <= '0;
        end else begin
            state     <= state_nxt;
            mask_q    <= mask_nxt;
            pending_q <= pending_nxt;
            data_q    <= data_nxt;
            if (count_inc) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask_q;
        pending_nxt = pending_q;
        data_nxt    = data_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        count_inc   = 1'b0;

        case (state)
            IDLE: begin
                // A mask load owns the cycle so the next token sees the new mask.
                in_ready = mask_nz & ~cfg_load;
                accept   = in_valid & in_ready;
                if (cfg_load) begin
                    mask_nxt = cfg_mask;
                end
                if (accept) begin
                    pending_nxt = mask_q;
                    data_nxt    = in_data;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                pending_nxt = pending_q & ~out_ready;
                in_ready    = last_clear & mask_nz;
                accept      = in_valid & in_ready;
                count_inc   = last_clear;
                if (accept) begin
                    pending_nxt = mask_q;
                    data_nxt    = in_data;
                end else if (last_clear) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_valid  = pending_q;
    assign out_data   = data_q;
    assign busy       = (state == HOLD);
    assign xfer_count = count_q;

endmodule

// File: tb/tb_fanout_bcast_ctrl.sv
// Bench for fanout_bcast_ctrl: scenario tasks drive stimulus and check inline,
// a negedge monitor scores every broadcast against a queue of accepted tokens.
module tb_fanout_bcast_ctrl;

    localparam int ND = 7;
    localparam int DW = 17;
    localparam int CW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [ND-1:0] mask;
    } tok_t;

    logic          CLK;
    logic          RESET;
    logic [ND-1:0] cfg_mask;
    logic          cfg_load;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [ND-1:0] out_valid;
    logic [DW-1:0] out_data;
    logic [ND-1:0] out_ready;
    logic          busy;
    logic [CW-1:0] xfer_count;

    int            n_cmp;
    int            n_err;
    tok_t          sb_q[$];
    logic [ND-1:0] exp_mask;
    logic [ND-1:0] delivered;
    logic [CW-1:0] exp_count;
    logic          acc_pend;
    logic [ND-1:0] acc_mask;

    fanout_bcast_ctrl #(.NUM_DEST(ND), .DATA_W(DW), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .cfg_mask   (cfg_mask),
        .cfg_load   (cfg_load),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: pop and score at broadcast completion, push on accept.
    always @(negedge CLK) begin
        if (RESET) begin
            sb_q.delete();
            delivered = '0;
            exp_count = '0;
            acc_pend  = 1'b0;
        end else begin
            n_cmp++;
            if (xfer_count !== exp_count) begin
                n_err++;
                $display("FAIL sb_count: got %0d want %0d", xfer_count, exp_count);
            end
            if (acc_pend) begin
                n_cmp++;
                if (out_valid !== acc_mask) begin
                    n_err++;
                    $display("FAIL sb_latency: out_valid got %b want %b", out_valid, acc_mask);
                end
                acc_pend = 1'b0;
            end
            if (out_valid != '0) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_spurious: out_valid %b with no token held", out_valid);
                end else begin
                    if (out_data !== sb_q[0].data) begin
                        n_err++;
                        $display("FAIL sb_data: got %h want %h", out_data, sb_q[0].data);
                    end
                    n_cmp++;
                    if ((out_valid & ~sb_q[0].mask) !== '0) begin
                        n_err++;
                        $display("FAIL sb_unmasked: out_valid %b mask %b", out_valid, sb_q[0].mask);
                    end
                    delivered = delivered | (out_valid & out_ready);
                    if ((out_valid & ~out_ready) == '0) begin
                        n_cmp++;
                        if (delivered !== sb_q[0].mask) begin
                            n_err++;
                            $display("FAIL sb_delivered: got %b want %b", delivered, sb_q[0].mask);
                        end
                        void'(sb_q.pop_front());
                        delivered = '0;
                        exp_count = exp_count + CW'(1);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{data: in_data, mask: exp_mask});
                acc_pend = 1'b1;
                acc_mask = exp_mask;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        out_ready = '0;
        exp_mask  = '0;
        step();
        RESET = 1'b0;
    endtask

    task automatic load_mask(input logic [ND-1:0] m);
        cfg_mask = m;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        exp_mask = m;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        n_cmp++;
        if ({in_ready, busy, out_valid, out_data, xfer_count} !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b busy=%b ov=%b od=%h cnt=%0d want all 0",
                     in_ready, busy, out_valid, out_data, xfer_count);
        end
        step();
    endtask

    task automatic test_no_mask();
        do_reset();
        in_valid = 1'b1;
        in_data  = 17'h00123;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (in_ready !== 1'b0 || xfer_count !== '0) begin
                n_err++;
                $display("FAIL no_mask: in_ready=%b cnt=%0d want 0/0", in_ready, xfer_count);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        load_mask(7'b0000101);
        in_valid  = 1'b1;
        in_data   = 17'h001A5;
        out_ready = '1;
        @(negedge CLK);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (out_valid !== 7'b0000101 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_valid: ov=%b busy=%b want 0000101/1", out_valid, busy);
        end
        step();
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0 || xfer_count !== 16'd1 || out_valid !== '0) begin
            n_err++;
            $display("FAIL single_done: busy=%b cnt=%0d ov=%b want 0/1/0", busy, xfer_count, out_valid);
        end
        step();
    endtask

    task automatic test_late_dest();
        do_reset();
        load_mask(7'b1111111);
        in_valid  = 1'b1;
        in_data   = 17'h0BEEF;
        out_ready = 7'b1110111;
        @(negedge CLK);
        step();
        in_valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (out_valid !== 7'b1111111) begin
            n_err++;
            $display("FAIL late_first: ov=%b want 1111111", out_valid);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (out_valid !== 7'b0001000 || out_data !== 17'h0BEEF) begin
                n_err++;
                $display("FAIL late_hold: ov=%b od=%h want 0001000/0beef", out_valid, out_data);
            end
            step();
        end
        out_ready = '1;
        step();
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0 || xfer_count !== 16'd1) begin
            n_err++;
            $display("FAIL late_done: busy=%b cnt=%0d want 0/1", busy, xfer_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_mask(7'b0000011);
        out_ready = '1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'h100 + i);
            @(negedge CLK);
            n_cmp++;
            if (in_ready !== 1'b1 || (i > 0 && busy !== 1'b1)) begin
                n_err++;
                $display("FAIL b2b_stream: tok %0d in_ready=%b busy=%b want 1/1", i, in_ready, busy);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge CLK);
        step();
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0 || xfer_count !== 16'd10) begin
            n_err++;
            $display("FAIL b2b_count: busy=%b cnt=%0d want 0/10", busy, xfer_count);
        end
        step();
    endtask

    task automatic test_cfg_hold();
        do_reset();
        load_mask(7'b0000110);
        in_valid  = 1'b1;
        in_data   = 17'h000AA;
        out_ready = '0;
        @(negedge CLK);
        step();
        in_valid = 1'b0;
        cfg_mask = 7'b0000001;
        cfg_load = 1'b1;
        @(negedge CLK);
        step();
        cfg_load = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (out_valid !== 7'b0000110) begin
            n_err++;
            $display("FAIL cfg_hold_ignored: ov=%b want 0000110", out_valid);
        end
        step();
        out_ready = '1;
        step();
        @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0 || xfer_count !== 16'd1) begin
            n_err++;
            $display("FAIL cfg_hold_done: busy=%b cnt=%0d want 0/1", busy, xfer_count);
        end
        // Load and token together in IDLE: the load takes the cycle.
        cfg_mask = 7'b0000001;
        cfg_load = 1'b1;
        in_valid = 1'b1;
        in_data  = 17'h00155;
        @(negedge CLK);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_wins: in_ready=%b want 0", in_ready);
        end
        step();
        cfg_load = 1'b0;
        exp_mask = 7'b0000001;
        @(negedge CLK);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_next_accept: in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
        step();
        in_valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (out_valid !== 7'b0000001) begin
            n_err++;
            $display("FAIL cfg_new_route: ov=%b want 0000001", out_valid);
        end
        step();
        step();
    endtask

    task automatic test_reset_hold();
        do_reset();
        load_mask(7'b0100000);
        in_valid  = 1'b1;
        in_data   = 17'h1F00F;
        out_ready = '0;
        @(negedge CLK);
        step();
        in_valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (out_valid !== 7'b0100000) begin
            n_err++;
            $display("FAIL rsth_pending: ov=%b want 0100000", out_valid);
        end
        step();
        RESET     = 1'b1;
        out_ready = '1;
        cfg_mask  = '1;
        cfg_load  = 1'b1;
        in_valid  = 1'b1;
        step();
        RESET    = 1'b0;
        cfg_load = 1'b0;
        exp_mask = '0;
        @(negedge CLK);
        n_cmp++;
        if (out_valid !== '0 || xfer_count !== '0 || busy !== 1'b0 ||
            in_ready !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL rsth_cleared: ov=%b cnt=%0d busy=%b rdy=%b od=%h want all 0",
                     out_valid, xfer_count, busy, in_ready, out_data);
        end
        step();
        in_valid  = 1'b0;
        out_ready = '0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        RESET     = 1'b1;
        cfg_mask  = '0;
        cfg_load  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
        exp_mask  = '0;
        delivered = '0;
        exp_count = '0;
        acc_pend  = 1'b0;
        acc_mask  = '0;
        test_reset();
        test_no_mask();
        test_single();
        test_late_dest();
        test_back_to_back();
        test_cfg_hold();
        test_reset_hold();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d tokens never completed, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
